// File: rtl/uartrx_if.sv
// Receiver-side signal bundle: serial line in, byte plus status out.
// Pure wiring, no latency; no backpressure (downstream must take rx_done when it pulses).
// master = the receiver, slave = the consumer that also owns the line.
interface uartrx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rxd,
        output rx_data, rx_done, parity_err, frame_err, rx_busy
    );

    modport slave (
        output rxd,
        input  rx_data, rx_done, parity_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uartrx.sv
// UART receiver, 16x oversampled, 8 data bits LSB first, parity, one stop bit.
// Latency: rx_done 170 clocks after the first edge that samples the start bit low.
// No backpressure: rx_done is a single-cycle strobe, outputs hold until the next frame.
module uartrx #(
    parameter logic PARITYMODE = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    uartrx_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state, state_nxt;
    logic       s1, s2, s3;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       par_bit, par_bit_nxt;
    logic [7:0] data_q, data_nxt;
    logic       done_q, done_nxt;
    logic       busy_q, busy_nxt;
    logic       perr_q, perr_nxt;
    logic       ferr_q, ferr_nxt;
    logic       start_edge;
    logic       mid_bit;

    // s3 is history only: a start needs a high-to-low transition, not just a low level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= bus.rxd;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start_edge = ~s2 & s3;
    assign mid_bit    = (cnt[3:0] == 4'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_bit_nxt;
            data_q  <= data_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
            perr_q  <= perr_nxt;
            ferr_q  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 8'd1;
        shreg_nxt   = shreg;
        par_bit_nxt = par_bit;
        data_nxt    = data_q;
        done_nxt    = 1'b0;
        busy_nxt    = busy_q;
        perr_nxt    = perr_q;
        ferr_nxt    = ferr_q;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_edge) begin
                    state_nxt = START;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                // Line back high at mid-start means a glitch: drop it silently
                if (cnt == 8'd7) begin
                    if (s2) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (mid_bit) begin
                    shreg_nxt = {s2, shreg[7:1]};
                    if (cnt == 8'd135) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (cnt == 8'd151) begin
                    par_bit_nxt = s2;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (cnt == 8'd167) begin
                    data_nxt  = shreg;
                    perr_nxt  = ((^shreg) ^ par_bit) != PARITYMODE;
                    ferr_nxt  = ~s2;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_done    = done_q;
    assign bus.rx_busy    = busy_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
endmodule
